fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 5-stage pipelined RISC-V core. Holds the program counter, selects the next PC (sequential, held, or redirected by a resolved branch/jump from Execute), and latches the fetched instruction into Decode. It applies the STALLF/STALLD/FLUSHD controls produced by the hazard unit, inserts NOP bubbles on flush, and keeps saturating stall/flush event counters and a sticky misaligned-target flag.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- CNT_W, 32, width of the stall and flush event counters.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- STALLF  in  1  hold PCF (hazard unit).
- STALLD  in  1  hold the IF/ID register (hazard unit).
- FLUSHD  in  1  replace IF/ID contents with a bubble (hazard unit).
- PCSRCE  in  1  branch/jump taken, resolved in Execute.
- PCTARGETE  in  32  redirect target from Execute.
- INSTR_MEM_RDATA  in  32  combinational instruction-memory read data for INSTR_MEM_ADDR.
- INSTR_MEM_ADDR  out  32  instruction-memory address; equals PCF.
- PCF  out  32  current fetch PC.
- INSTRD  out  32  instruction in Decode.
- PCD  out  32  PC of INSTRD.
- PCPLUS4D  out  32  PCD + 4.
- VALIDD  out  1  1 = INSTRD is a real fetched instruction, 0 = bubble.
- STALL_CNT  out  CNT_W  cycles with STALLD=1 and FLUSHD=0.
- FLUSH_CNT  out  CNT_W  cycles with FLUSHD=1.
- MISALIGN_ERR  out  1  sticky: a redirect with PCTARGETE[1:0] != 0 occurred.

## Operation
- Next-PC priority (evaluated each cycle, registered on edge): RST -> RESET_PC; else PCSRCE=1 -> {PCTARGETE[31:2], 2'b00}; else STALLF=1 -> PCF; else PCF + 4.
- PCSRCE overrides STALLF: a taken redirect is never lost to a simultaneous stall.
- PCF + 4 is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- IF/ID register priority: RST -> reset values; else FLUSHD=1 -> INSTRD=32'h0000_0013 (addi x0,x0,0), PCD=0, PCPLUS4D=0, VALIDD=0; else STALLD=1 -> hold all four; else INSTRD=INSTR_MEM_RDATA, PCD=PCF, PCPLUS4D=PCF+4 (same wrap), VALIDD=1.
- FLUSHD overrides STALLD when both are asserted.
- MISALIGN_ERR: set on any cycle with PCSRCE=1 and PCTARGETE[1:0] != 2'b00; cleared only by RST. The redirect still proceeds with the low bits forced to 0.
- STALL_CNT increments on cycles with STALLD=1 and FLUSHD=0. FLUSH_CNT increments on cycles with FLUSHD=1. Both saturate at all-ones and never wrap.
- Reset values: PCF=RESET_PC, INSTRD=32'h0000_0013, PCD=0, PCPLUS4D=0, VALIDD=0, STALL_CNT=0, FLUSH_CNT=0, MISALIGN_ERR=0.

## Timing
- INSTR_MEM_ADDR is combinational from PCF, with zero latency. The memory returns data in the same cycle.
- Fetch-to-Decode latency is 1 cycle: the instruction at PCF in cycle n appears on INSTRD in cycle n+1.
- Redirect: PCSRCE=1 in cycle n gives PCF=target in n+1, and the target instruction on INSTRD in n+2. With FLUSHD=1 in n, INSTRD in n+1 is a bubble.
- Stall: with STALLF=STALLD=1 in cycle n, PCF and IF/ID hold in n+1 and fetch resumes from the held PCF.
- RST asserted mid-stream takes effect at the next edge regardless of any other input. The first fetch after RST deasserts uses RESET_PC.
- Counters and MISALIGN_ERR are registered, so they update 1 cycle after the qualifying event.

## Test plan
- Reset then free-run with memory returning addr-derived data: PCF = 0, 4, 8, ... In cycle 3, INSTRD = data for PC 8, PCD=8, PCPLUS4D=12, VALIDD=1.
- Load-use stall: STALLF=STALLD=1 for 1 cycle while PCF=0x10 -> PCF stays 0x10 for one extra cycle, INSTRD holds the 0xC instruction, STALL_CNT=1, and the sequence resumes at 0x14.
- Taken branch: PCSRCE=1, PCTARGETE=0x100, FLUSHD=1 while PCF=0x20 -> next cycle PCF=0x100, INSTRD=0x00000013, VALIDD=0, FLUSH_CNT=1; following cycle PCD=0x100, VALIDD=1.
- Simultaneous STALLF=1, STALLD=1, PCSRCE=1, FLUSHD=1 -> PCF becomes the target, IF/ID becomes a bubble, FLUSH_CNT increments, and STALL_CNT does not.
- Misaligned redirect PCTARGETE=0x203 -> PCF=0x200 and MISALIGN_ERR=1, which stays 1 until RST. Redirect to 0xFFFFFFFC -> next PCF=0x00000000 and PCPLUS4D=0.
- Counter saturation with CNT_W=4: hold STALLD=1 for 20 cycles -> STALL_CNT reaches 15 and stays there. RST asserted mid-stall -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, next-PC select and IF/ID pipeline register with
// hazard controls, saturating stall/flush counters and a sticky misaligned-target flag.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             STALLF,
   input  logic             STALLD,
   input  logic             FLUSHD,
   input  logic             PCSRCE,
   input  logic [31:0]      PCTARGETE,
   input  logic [31:0]      INSTR_MEM_RDATA,
   output logic [31:0]      INSTR_MEM_ADDR,
   output logic [31:0]      PCF,
   output logic [31:0]      INSTRD,
   output logic [31:0]      PCD,
   output logic [31:0]      PCPLUS4D,
   output logic             VALIDD,
   output logic [CNT_W-1:0] STALL_CNT,
   output logic [CNT_W-1:0] FLUSH_CNT,
   output logic             MISALIGN_ERR
);
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic [31:0]      pcf_q, pcf_d, instrd_q, instrd_d, pcd_q, pcd_d, pcplus4d_q, pcplus4d_d;
   logic [31:0]      pc_plus4;
   logic             validd_q, validd_d, misalign_q, misalign_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   assign pc_plus4 = pcf_q + 32'd4;
   always_comb begin
      // a taken redirect wins over a fetch stall; a flush wins over a decode stall
      pcf_d       = PCSRCE ? {PCTARGETE[31:2], 2'b00} : STALLF ? pcf_q : pc_plus4;
      instrd_d    = FLUSHD ? NOP   : STALLD ? instrd_q   : INSTR_MEM_RDATA;
      pcd_d       = FLUSHD ? '0    : STALLD ? pcd_q      : pcf_q;
      pcplus4d_d  = FLUSHD ? '0    : STALLD ? pcplus4d_q : pc_plus4;
      validd_d    = FLUSHD ? 1'b0  : STALLD ? validd_q   : 1'b1;
      misalign_d  = misalign_q | (PCSRCE & (PCTARGETE[1:0] != 2'b00));
      stall_cnt_d = (STALLD && !FLUSHD && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
      flush_cnt_d = (FLUSHD && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         pcf_q       <= RESET_PC;
         instrd_q    <= NOP;
         pcd_q       <= '0;
         pcplus4d_q  <= '0;
         validd_q    <= 1'b0;
         misalign_q  <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         pcf_q       <= pcf_d;
         instrd_q    <= instrd_d;
         pcd_q       <= pcd_d;
         pcplus4d_q  <= pcplus4d_d;
         validd_q    <= validd_d;
         misalign_q  <= misalign_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
   assign INSTR_MEM_ADDR = pcf_q;
   assign PCF            = pcf_q;
   assign INSTRD         = instrd_q;
   assign PCD            = pcd_q;
   assign PCPLUS4D       = pcplus4d_q;
   assign VALIDD         = validd_q;
   assign STALL_CNT      = stall_cnt_q;
   assign FLUSH_CNT      = flush_cnt_q;
   assign MISALIGN_ERR   = misalign_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plan scenarios plus randomized hazard traffic, checked against
// a behavioural model of the fetch stage kept as plain variables.
module tb_fetch_stage;
   localparam int CNT_W = 4;
   localparam int SAT   = (1 << CNT_W) - 1;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic             clk = 1'b0;
   logic             rst = 1'b1, stallf = 1'b0, stalld = 1'b0, flushd = 1'b0, pcsrce = 1'b0;
   logic [31:0]      pctargete = '0;
   logic [31:0]      rdata, addr, pcf, instrd, pcd, pcplus4d;
   logic             validd, misalign;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   int               n_cmp = 0, n_err = 0;
   logic [31:0]      m_pc = '0, m_instr = NOP, m_pcd = '0, m_pc4 = '0;
   logic             m_valid = 1'b0, m_mis = 1'b0;
   int               m_sc = 0, m_fc = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   assign rdata = mem(addr);

   fetch_stage #(.RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
      .CLK(clk), .RST(rst), .STALLF(stallf), .STALLD(stalld), .FLUSHD(flushd),
      .PCSRCE(pcsrce), .PCTARGETE(pctargete), .INSTR_MEM_RDATA(rdata),
      .INSTR_MEM_ADDR(addr), .PCF(pcf), .INSTRD(instrd), .PCD(pcd), .PCPLUS4D(pcplus4d),
      .VALIDD(validd), .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt), .MISALIGN_ERR(misalign)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("pcf", pcf, m_pc);
      chk("addr", addr, m_pc);
      chk("instrd", instrd, m_instr);
      chk("pcd", pcd, m_pcd);
      chk("pcplus4d", pcplus4d, m_pc4);
      chk("validd", {31'b0, validd}, {31'b0, m_valid});
      chk("stall_cnt", 32'(stall_cnt), 32'(m_sc));
      chk("flush_cnt", 32'(flush_cnt), 32'(m_fc));
      chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
   endtask

   // one clock: model computes the post-edge state from the inputs applied this cycle
   task automatic step();
      logic [31:0] n_pc, n_instr, n_pcd, n_pc4;
      logic        n_valid, n_mis;
      int          n_sc, n_fc;
      if (rst) begin
         n_pc = 0; n_instr = NOP; n_pcd = 0; n_pc4 = 0; n_valid = 0; n_mis = 0; n_sc = 0; n_fc = 0;
      end else begin
         n_pc = pcsrce ? (pctargete & ~32'd3) : stallf ? m_pc : m_pc + 32'd4;
         if (flushd) begin
            n_instr = NOP; n_pcd = 0; n_pc4 = 0; n_valid = 0;
         end else if (stalld) begin
            n_instr = m_instr; n_pcd = m_pcd; n_pc4 = m_pc4; n_valid = m_valid;
         end else begin
            n_instr = mem(m_pc); n_pcd = m_pc; n_pc4 = m_pc + 32'd4; n_valid = 1;
         end
         n_mis = m_mis || (pcsrce && pctargete[1:0] != 0);
         n_sc  = (stalld && !flushd) ? ((m_sc < SAT) ? m_sc + 1 : SAT) : m_sc;
         n_fc  = flushd ? ((m_fc < SAT) ? m_fc + 1 : SAT) : m_fc;
      end
      @(posedge clk);
      #1;
      m_pc = n_pc; m_instr = n_instr; m_pcd = n_pcd; m_pc4 = n_pc4;
      m_valid = n_valid; m_mis = n_mis; m_sc = n_sc; m_fc = n_fc;
      check_model();
   endtask

   task automatic idle();
      rst = 0; stallf = 0; stalld = 0; flushd = 0; pcsrce = 0; pctargete = '0;
   endtask

   initial begin
      rst = 1;
      step();
      chk("rst_pcf", pcf, 32'h0);
      chk("rst_instrd", instrd, NOP);
      idle();
      repeat (3) step();
      chk("run_instrd", instrd, mem(32'h8));
      chk("run_pcd", pcd, 32'h8);
      chk("run_pc4", pcplus4d, 32'hC);
      step();
      chk("pre_stall_pcf", pcf, 32'h10);
      stallf = 1; stalld = 1;
      step();
      chk("stall_pcf", pcf, 32'h10);
      chk("stall_instrd", instrd, mem(32'hC));
      chk("stall_cnt1", 32'(stall_cnt), 32'd1);
      idle();
      step();
      chk("resume_pcf", pcf, 32'h14);
      repeat (3) step();
      chk("pre_br_pcf", pcf, 32'h20);
      pcsrce = 1; pctargete = 32'h100; flushd = 1;
      step();
      chk("br_pcf", pcf, 32'h100);
      chk("br_bubble", instrd, NOP);
      chk("br_valid", {31'b0, validd}, 32'd0);
      chk("br_fcnt", 32'(flush_cnt), 32'd1);
      idle();
      step();
      chk("br_pcd", pcd, 32'h100);
      chk("br_valid2", {31'b0, validd}, 32'd1);
      stallf = 1; stalld = 1; pcsrce = 1; flushd = 1; pctargete = 32'h40;
      step();
      chk("all_pcf", pcf, 32'h40);
      chk("all_valid", {31'b0, validd}, 32'd0);
      chk("all_fcnt", 32'(flush_cnt), 32'd2);
      chk("all_scnt", 32'(stall_cnt), 32'd1);
      idle();
      pcsrce = 1; pctargete = 32'h203;
      step();
      chk("mis_pcf", pcf, 32'h200);
      chk("mis_flag", {31'b0, misalign}, 32'd1);
      pctargete = 32'hFFFF_FFFC;
      step();
      idle();
      step();
      chk("wrap_pcf", pcf, 32'h0);
      chk("wrap_pcd", pcd, 32'hFFFF_FFFC);
      chk("wrap_pc4", pcplus4d, 32'h0);
      chk("mis_sticky", {31'b0, misalign}, 32'd1);
      stalld = 1;
      repeat (20) step();
      chk("sat_scnt", 32'(stall_cnt), 32'(SAT));
      rst = 1;
      step();
      chk("midrst_scnt", 32'(stall_cnt), 32'd0);
      chk("midrst_mis", {31'b0, misalign}, 32'd0);
      chk("midrst_pcf", pcf, 32'h0);
      idle();
      for (int i = 0; i < 3000; i++) begin
         logic s;
         s         = ($urandom_range(0, 5) == 0);
         rst       = ($urandom_range(0, 199) == 0);
         stallf    = s | ($urandom_range(0, 19) == 0);
         stalld    = s | ($urandom_range(0, 19) == 0);
         pcsrce    = ($urandom_range(0, 7) == 0);
         flushd    = pcsrce ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 29) == 0);
         pctargete = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                   : ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & ~32'd3);
         step();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
